// File: rtl/oe_pkg.sv
// Shared mode/direction encodings and default parameters for the operand-entry controller.
package oe_pkg;

  typedef enum logic {
    MODE_DEMO = 1'b0,
    MODE_CALC = 1'b1
  } mode_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  localparam int DEF_W            = 8;
  localparam int DEF_HOLD_TICKS   = 50;
  localparam int DEF_REPEAT_TICKS = 10;
  localparam int DEF_AUTO_TICKS   = 100;
  localparam bit DEF_WRAP         = 1'b1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_repeat.sv
// Edge detector plus hold counter producing a combinational step pulse for one key.
// Steps on the edge (optional), HOLD cycles later, then every REPEAT cycles while held.
module key_repeat #(
  parameter bit FIRST_ON_EDGE = 1'b1,
  parameter int HOLD          = 50,
  parameter int REPEAT        = 10,
  parameter int CW            = 7
) (
  input  logic clk_100hz,
  input  logic rst_,
  input  logic en,
  input  logic key,
  output logic step
);

  // Without an edge step the first fire lands on the HOLD-th high cycle, one earlier.
  localparam int THR    = FIRST_ON_EDGE ? HOLD : HOLD - 1;
  localparam int RELOAD = THR - REPEAT + 1;

  localparam logic [CW-1:0] THR_C    = CW'(THR);
  localparam logic [CW-1:0] RELOAD_C = CW'(RELOAD);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  logic          prev;
  logic [CW-1:0] cnt;
  logic          edge_hit;
  logic          cnt_hit;

  assign edge_hit = FIRST_ON_EDGE && key && !prev;
  assign cnt_hit  = key && (cnt == THR_C);
  assign step     = en && (edge_hit || cnt_hit);

  always_ff @(posedge clk_100hz or negedge rst_) begin
    if (!rst_) begin
      prev <= 1'b0;
      cnt  <= '0;
    end else begin
      prev <= key;
      if (!(en && key)) begin
        cnt <= '0;
      end else if (cnt_hit) begin
        cnt <= RELOAD_C;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/operand_entry_ctrl.sv
// DEMO/CALC mode FSM, step direction, wrap/saturate operand stepping and multiplier commit.
// All outputs registered; a key edge sampled at clock n is visible the cycle after.
module operand_entry_ctrl
  import oe_pkg::*;
#(
  parameter int W            = DEF_W,
  parameter int HOLD_TICKS   = DEF_HOLD_TICKS,
  parameter int REPEAT_TICKS = DEF_REPEAT_TICKS,
  parameter int AUTO_TICKS   = DEF_AUTO_TICKS,
  parameter bit WRAP         = DEF_WRAP
) (
  input  logic         clk_100hz,
  input  logic         rst_,
  input  logic         key_mode,
  input  logic         key_inc_x,
  input  logic         key_inc_y,
  input  logic         key_dir,
  input  logic         key_load,
  input  logic         key_auto,
  output logic         mode,
  output logic         dir,
  output logic [W-1:0] op_x,
  output logic [W-1:0] op_y,
  output logic [W-1:0] mul_x,
  output logic [W-1:0] mul_y,
  output logic         load_pulse
);

  localparam int CW = $clog2(max_int(HOLD_TICKS, AUTO_TICKS) + 1);

  mode_t        mode_q;
  logic         mode_prev, dir_prev, load_prev;
  logic         calc, mode_edge, dir_edge, load_edge;
  logic         step_x_man, step_y_man, step_auto;
  logic         step_x, step_y;
  logic [W-1:0] nx, ny;

  function automatic logic [W-1:0] step_val(input logic [W-1:0] v, input logic down);
    if (down == DIR_DOWN) begin
      return (v == '0 && !WRAP) ? v : v - W'(1);
    end
    return (v == '1 && !WRAP) ? v : v + W'(1);
  endfunction

  assign mode      = mode_q;
  assign calc      = (mode_q == MODE_CALC);
  assign mode_edge = key_mode & ~mode_prev;
  assign dir_edge  = key_dir & ~dir_prev;
  assign load_edge = key_load & ~load_prev;

  key_repeat #(.FIRST_ON_EDGE(1'b1), .HOLD(HOLD_TICKS), .REPEAT(REPEAT_TICKS), .CW(CW)) u_rep_x (
    .clk_100hz(clk_100hz), .rst_(rst_), .en(calc), .key(key_inc_x), .step(step_x_man)
  );

  key_repeat #(.FIRST_ON_EDGE(1'b1), .HOLD(HOLD_TICKS), .REPEAT(REPEAT_TICKS), .CW(CW)) u_rep_y (
    .clk_100hz(clk_100hz), .rst_(rst_), .en(calc), .key(key_inc_y), .step(step_y_man)
  );

  key_repeat #(.FIRST_ON_EDGE(1'b0), .HOLD(AUTO_TICKS), .REPEAT(AUTO_TICKS), .CW(CW)) u_rep_auto (
    .clk_100hz(clk_100hz), .rst_(rst_), .en(calc), .key(key_auto), .step(step_auto)
  );

  // Manual and auto steps on the same operand merge into a single step using the current dir.
  assign step_x = step_x_man | step_auto;
  assign step_y = step_y_man | step_auto;
  assign nx     = step_x ? step_val(op_x, dir) : op_x;
  assign ny     = step_y ? step_val(op_y, dir) : op_y;

  always_ff @(posedge clk_100hz or negedge rst_) begin
    if (!rst_) begin
      mode_q     <= MODE_DEMO;
      mode_prev  <= 1'b0;
      dir_prev   <= 1'b0;
      load_prev  <= 1'b0;
      dir        <= DIR_UP;
      op_x       <= '0;
      op_y       <= '0;
      mul_x      <= '0;
      mul_y      <= '0;
      load_pulse <= 1'b0;
    end else begin
      mode_prev  <= key_mode;
      dir_prev   <= key_dir;
      load_prev  <= key_load;
      load_pulse <= 1'b0;
      if (mode_edge) begin
        mode_q <= calc ? MODE_DEMO : MODE_CALC;
      end
      if (calc) begin
        if (dir_edge) begin
          dir <= ~dir;
        end
        op_x <= nx;
        op_y <= ny;
        // An auto fire commits the stepped values; a plain load commits the pre-step ones.
        if (step_auto) begin
          mul_x      <= nx;
          mul_y      <= ny;
          load_pulse <= 1'b1;
        end else if (load_edge) begin
          mul_x      <= op_x;
          mul_y      <= op_y;
          load_pulse <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/operand_entry_ctrl.md
# operand_entry_ctrl

Parametrised operand-entry and mode controller for the multiplier demo. It sits between the key_handler debouncers and the pipelined multiplier / display mux. It owns the DEMO/CALC mode state machine, edge-detected key events, hold-to-repeat stepping in either direction, wrap or saturate arithmetic, and committing operands to the multiplier with a one-cycle load strobe.

## Interface
- W, 8: operand width in bits, ≥2.
- HOLD_TICKS, 50: cycles a step key must stay held after its edge before auto-repeat starts.
- REPEAT_TICKS, 10: cycles between auto-repeat steps.
- AUTO_TICKS, 100: period of the auto-sweep step while key_auto is held.
- WRAP, 1: 1 = modular step, 0 = saturate at 0 and 2^W−1.
- clk_100hz  in  1  key sample clock.
- rst_  in  1  reset, asynchronous, active-low.
- key_mode, key_inc_x, key_inc_y, key_dir, key_load, key_auto  in  1 each  debounced key levels, active-high.
- mode  out  1  0 = DEMO, 1 = CALC.
- dir  out  1  step direction, 0 = up, 1 = down.
- op_x, op_y  out  W each  live entry values.
- mul_x, mul_y  out  W each  committed multiplier operands.
- load_pulse  out  1  high for one cycle on each commit.

## Operation
- All outputs are registered. Reset values: mode=DEMO, dir=0, op_x=op_y=mul_x=mul_y=0, load_pulse=0. All edge and previous-level registers and counters are also 0.
- Edge = level & ~prev. Because prev resets to 0, a key held through reset release produces one edge on the first clock.
- Mode FSM:
  - DEMO → CALC and CALC → DEMO, on each key_mode edge.
  - In DEMO every other key is ignored, hold counters are held at 0, and op/mul/dir keep their values.
- CALC, key_inc_x (and likewise key_inc_y):
  - An edge steps op_x by +1 (dir=0) or −1 (dir=1).
  - While the key stays high, the hold counter runs. Further steps occur HOLD_TICKS cycles after the edge, then every REPEAT_TICKS.
  - Releasing the key clears the counter.
- CALC, key_dir: an edge toggles dir.
- CALC, key_load: an edge sets mul_x←op_x and mul_y←op_y and asserts load_pulse.
- CALC, key_auto: while held, a counter runs. On every AUTO_TICKS-th consecutive high cycle:
  - both operands step by dir;
  - mul_x/mul_y take the stepped values;
  - load_pulse asserts.
- Arithmetic:
  - WRAP=1: 2^W−1 + 1 = 0 and 0 − 1 = 2^W−1.
  - WRAP=0: the value clamps at the limit. A clamped step still counts as a step event but leaves the value unchanged.
- Simultaneous events:
  - Every event in a cycle is evaluated against the current registered state. A key_mode edge in the same cycle as other keys does not suppress them if the current mode is CALC.
  - Manual and auto steps on the same operand in the same cycle combine into one step.
  - A key_dir edge coincident with a step: the step uses the old dir.
  - Auto fire coincident with a load edge: mul takes the stepped values, and load_pulse is a single cycle.
  - A load edge coincident with a manual step only: mul takes the pre-step op values.
- Reset mid-hold or mid-sweep: everything returns to reset values immediately and asynchronously. No step is completed.

## Timing
- Key sampled high at clock n (prev=0) → op/mul/dir/mode update at clock n; visible in cycle n+1. Latency is 1 cycle.
- Hold sequence for a key high from clock t0: steps at t0, t0+HOLD_TICKS, t0+HOLD_TICKS+k·REPEAT_TICKS.
- Auto sweep for key_auto high from clock t0: fires at t0+AUTO_TICKS−1+k·AUTO_TICKS.
- load_pulse is exactly one cycle wide and aligned with the mul update.
- Counter width is $clog2(max(HOLD_TICKS, AUTO_TICKS)+1). Counters saturate and never wrap.

## Structure
- Package oe_pkg: the mode encoding constants (MODE_DEMO, MODE_CALC), the direction constants, and the default parameter values.
- One sub-module, key_repeat, instantiated three times (x, y, auto).
  - It contains the edge detector, hold counter and step-pulse output.
  - Parameters: FIRST_ON_EDGE, HOLD, REPEAT, and an enable input. The enable is held low in DEMO.
  - The auto instance uses FIRST_ON_EDGE=0 and HOLD=REPEAT=AUTO_TICKS.
- The top level holds the mode FSM, the dir register, step/saturate arithmetic and commit logic.

## Test plan
- Reset, then key_inc_x pulsed in DEMO → op_x stays 0 and mode stays 0. Then a key_mode pulse → mode=1 after 1 cycle.
- CALC, W=8, WRAP=1, op_x=255, one key_inc_x pulse → op_x=0. Then key_dir pulse plus key_inc_x pulse → op_x=255.
- CALC, WRAP=0, op_y=0, dir=1, key_inc_y pulse → op_y stays 0. With dir=0 and op_y=255, key_inc_y pulse → op_y stays 255.
- CALC, key_inc_x held for 80 cycles with defaults (HOLD_TICKS=50, REPEAT_TICKS=10) → steps at cycles 0, 50, 60 and 70, so op_x goes from 0 to 4.
- CALC, op_x=3, op_y=5, key_load pulse → mul_x=3, mul_y=5, load_pulse high for exactly 1 cycle.
- CALC, op_x=op_y=0, key_auto held for 250 cycles (AUTO_TICKS=100) → two fires, at cycles 99 and 199. Final op_x=op_y=mul_x=mul_y=2, and load_pulse pulsed twice. Asserting rst_=0 at cycle 150 of a repeat run → all outputs become 0 at once.
